scan_addr_gen: RTL and testbench
================================

Name: scan_addr_gen

Overview:
- Parametrised image scan-address generator; the next generation of the single-image index counter.
- Emits one linear pixel index per accepted transfer, walking a W x H image in one of four orders: row-major, column-major, anti-diagonal (up-right) or diagonal (up-left).
- Marks line boundaries so the downstream edge detector resets per line.
- Sits between the frame buffer read port and the edge-detection stage, with a valid/ready handshake replacing free-running enable.

Parameters:
- IMG_W, 150, image width in pixels (>=2).
- IMG_H, 150, image height in pixels (>=2).
- ADDR_W, $clog2(IMG_W*IMG_H), width of linear index.
- COORD_W, $clog2(max(IMG_W,IMG_H)), width of row/col counters.

Ports:
- clk  in  1  clock, rising edge.
- resetIn  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame scan; sampled only in IDLE.
- mode  in  2  00 LR row-major, 01 UD column-major, 10 TTL anti-diagonal, 11 TTR diagonal; latched on start.
- addr_valid  out  1  addr holds a valid index.
- addr_ready  in  1  consumer accepts addr this cycle.
- addr  out  ADDR_W  linear index, row*IMG_W+col.
- line_start  out  1  qualifies addr: first element of a line.
- line_end  out  1  qualifies addr: last element of a line (edge detector reset).
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the final element is accepted.

Behaviour:
- Reset values (async on resetIn): state IDLE, addr=0, addr_valid=0, line_start=0, line_end=0, busy=0, done=0, internal counters 0.
- FSM states:
  - IDLE: start=1 latches mode, loads the first element, then goes to SCAN next cycle (addr_valid=1, busy=1). Start-to-first-valid latency is 1 cycle.
  - SCAN: advance only on addr_valid&&addr_ready. addr, line_start and line_end must hold stable while valid&&!ready. start is ignored.
  - FIN: entered when the last element is accepted. addr_valid=0, done=1 for exactly one cycle, then IDLE.
- No multiplier. addr and a line_base register update incrementally by +/-1, +/-IMG_W, -(IMG_W-1) or -(IMG_W+1). Row/col counters decide wrap.
- LR: col++, addr++. At col=IMG_W-1, line_end=1 and the next element is col=0, row+1. IMG_H lines.
- UD: addr+=IMG_W. At row=IMG_H-1, line_end=1 and addr=line_base+1 (next column). IMG_W lines.
- TTL:
  - Step row-1, col+1, addr-=(IMG_W-1).
  - Line ends when row=0 or col=IMG_W-1.
  - Line starts go down column 0 (line_base+=IMG_W) until row IMG_H-1, then along the bottom row (line_base+=1).
  - IMG_W+IMG_H-1 lines.
- TTR:
  - Step row-1, col-1, addr-=(IMG_W+1).
  - Line ends when row=0 or col=0.
  - Line starts go down column IMG_W-1 (+=IMG_W), then along the bottom row leftward (-=1).
  - IMG_W+IMG_H-1 lines.
- Single-element lines (corners) assert line_start and line_end together.
- Frame completes at the last element: LR/UD index IMG_W*IMG_H-1; TTL IMG_W*IMG_H-1; TTR IMG_W*(IMG_H-1).
- resetIn mid-scan aborts immediately to reset values. No done pulse.
- start coincident with done (FIN cycle) is ignored. start must be re-presented in IDLE.

Optional Feature:
- Macro: SCAN_COORD_EN.
- Defined: adds outputs row_out and col_out [COORD_W-1:0], qualified by addr_valid and aligned with addr, for debug and boundary-aware filters. Both reset to 0.
- Undefined: ports absent, counters internal only. Behaviour is otherwise identical.

Decomposition:
- Shared package scan_pkg holds:
  - mode encodings SCAN_LR, SCAN_UD, SCAN_TTL, SCAN_TTR;
  - FSM state typedef (IDLE/SCAN/FIN);
  - default IMG_W/IMG_H constants.
- One natural sub-module: scan_step, a combinational next-element calculator. It takes mode, row, col, addr and line_base, and returns next values plus line_end and last flags. The top level holds registers, FSM and handshake.

Test Plan:
- IMG_W=4, IMG_H=3, mode LR, ready=1: addr 0..11. line_end at 3,7,11. done one cycle after 11 is accepted.
- Same dims, UD: addr 0,4,8,1,5,9,2,6,10,3,7,11. line_end at 8,9,10,11.
- Same dims, TTL: 0 | 4,1 | 8,5,2 | 9,6,3 | 10,7 | 11. Address 0 has line_start=line_end=1. 6 line_end pulses.
- Same dims, TTR: 3 | 7,2 | 11,6,1 | 10,5,0 | 9,4 | 8. done after 8.
- Backpressure: random addr_ready toggling in TTL. The address sequence is identical to the ready=1 run, and outputs stay stable while stalled. start pulsed mid-scan is ignored.
- Default 150x150 LR: 22500 accepts, last addr 22499. Then resetIn asserted mid-UD scan at addr 300: all outputs 0 next edge, no done, and a new start restarts from addr 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the image scan-address generator: scan order
// encodings, controller state encoding and default image dimensions.
package scan_pkg;

  localparam int IMG_W_DEF = 150;
  localparam int IMG_H_DEF = 150;

  typedef enum logic [1:0] {
    SCAN_LR  = 2'b00,  // row-major
    SCAN_UD  = 2'b01,  // column-major
    SCAN_TTL = 2'b10,  // anti-diagonal, stepping up-right
    SCAN_TTR = 2'b11   // diagonal, stepping up-left
  } scan_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    FIN  = 2'b10
  } scan_state_e;

endpackage

// File: rtl/scan_step.sv
// Combinational next-element calculator for the scan-address generator.
// Given the current element (row, col, linear addr) and the address of the
// first element of the current line, it produces the following element using
// only add/subtract by small constants. The diagonal modes use the row+col
// sum of the current line to locate where the next line starts.
module scan_step
  import scan_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = $clog2(IMG_W * IMG_H),
  parameter int COORD_W = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [ADDR_W-1:0]  line_base,
  output logic [COORD_W-1:0] nxt_row,
  output logic [COORD_W-1:0] nxt_col,
  output logic [ADDR_W-1:0]  nxt_addr,
  output logic [ADDR_W-1:0]  nxt_line_base,
  output logic               line_end,
  output logic               last,
  output logic               nxt_line_end
);

  localparam int SUM_W = COORD_W + 2;
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [ADDR_W-1:0]  A_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  A_W     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]  A_WM1   = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0]  A_WP1   = ADDR_W'(IMG_W + 1);

  // Does element (r, c) close a line in scan order m?
  function automatic logic eol(input logic [1:0] m,
                               input logic [COORD_W-1:0] r,
                               input logic [COORD_W-1:0] c);
    logic res;
    case (m)
      SCAN_LR:  res = (c == COL_MAX);
      SCAN_UD:  res = (r == ROW_MAX);
      SCAN_TTL: res = (r == '0) || (c == COL_MAX);
      SCAN_TTR: res = (r == '0) || (c == '0);
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

  logic [SUM_W-1:0] ttl_sum_s;  // row + col, constant along an up-right line
  logic [SUM_W-1:0] ttr_sum_s;  // row + (W-1-col), constant along an up-left line

  assign ttl_sum_s = SUM_W'(row) + SUM_W'(col);
  assign ttr_sum_s = SUM_W'(row) + SUM_W'(COL_MAX) - SUM_W'(col);

  assign line_end     = eol(mode, row, col);
  assign nxt_line_end = eol(mode, nxt_row, nxt_col);

  // Final element of the frame: bottom-right, except bottom-left for TTR.
  always_comb begin
    if (mode == SCAN_TTR) begin
      last = (row == ROW_MAX) && (col == '0);
    end else begin
      last = (row == ROW_MAX) && (col == COL_MAX);
    end
  end

  // Next-element computation per scan order.
  always_comb begin
    nxt_row       = row;
    nxt_col       = col;
    nxt_addr      = addr;
    nxt_line_base = line_base;
    case (mode)
      SCAN_LR: begin
        nxt_addr = addr + A_ONE;
        if (line_end) begin
          nxt_row       = row + C_ONE;
          nxt_col       = '0;
          nxt_line_base = addr + A_ONE;
        end else begin
          nxt_col = col + C_ONE;
        end
      end
      SCAN_UD: begin
        if (line_end) begin
          nxt_row       = '0;
          nxt_col       = col + C_ONE;
          nxt_line_base = line_base + A_ONE;
          nxt_addr      = line_base + A_ONE;
        end else begin
          nxt_row  = row + C_ONE;
          nxt_addr = addr + A_W;
        end
      end
      SCAN_TTL: begin
        if (line_end) begin
          if (ttl_sum_s < SUM_W'(IMG_H - 1)) begin
            nxt_row       = COORD_W'(ttl_sum_s + SUM_W'(1));
            nxt_col       = '0;
            nxt_line_base = line_base + A_W;
            nxt_addr      = line_base + A_W;
          end else begin
            nxt_row       = ROW_MAX;
            nxt_col       = COORD_W'(ttl_sum_s + SUM_W'(2) - SUM_W'(IMG_H));
            nxt_line_base = line_base + A_ONE;
            nxt_addr      = line_base + A_ONE;
          end
        end else begin
          nxt_row  = row - C_ONE;
          nxt_col  = col + C_ONE;
          nxt_addr = addr - A_WM1;
        end
      end
      SCAN_TTR: begin
        if (line_end) begin
          if (ttr_sum_s < SUM_W'(IMG_H - 1)) begin
            nxt_row       = COORD_W'(ttr_sum_s + SUM_W'(1));
            nxt_col       = COL_MAX;
            nxt_line_base = line_base + A_W;
            nxt_addr      = line_base + A_W;
          end else begin
            nxt_row       = ROW_MAX;
            nxt_col       = COORD_W'(SUM_W'(IMG_W + IMG_H - 3) - ttr_sum_s);
            nxt_line_base = line_base - A_ONE;
            nxt_addr      = line_base - A_ONE;
          end
        end else begin
          nxt_row  = row - C_ONE;
          nxt_col  = col - C_ONE;
          nxt_addr = addr - A_WP1;
        end
      end
      default: begin
        nxt_row       = row;
        nxt_col       = col;
        nxt_addr      = addr;
        nxt_line_base = line_base;
      end
    endcase
  end

endmodule

// File: rtl/scan_addr_gen.sv
// Image scan-address generator: walks an IMG_W x IMG_H image in one of four
// orders, presenting one linear index per valid/ready transfer with line
// start/end qualifiers and a done pulse after the final element.
// Optional build macro SCAN_COORD_EN exposes the row/col counters as
// row_out/col_out, aligned with addr.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = $clog2(IMG_W * IMG_H),
  parameter int COORD_W = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
  input  logic               clk,
  input  logic               resetIn,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [ADDR_W-1:0]  addr,
  output logic               line_start,
  output logic               line_end,
  output logic               busy,
`ifdef SCAN_COORD_EN
  output logic [COORD_W-1:0] row_out,
  output logic [COORD_W-1:0] col_out,
`endif
  output logic               done
);

  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0]  A_WM1   = ADDR_W'(IMG_W - 1);

  scan_state_e        state_r, state_s;
  logic [1:0]         mode_r, mode_s;
  logic [COORD_W-1:0] row_r, row_s, col_r, col_s;
  logic [ADDR_W-1:0]  addr_r, addr_s, base_r, base_s;
  logic               valid_r, valid_s, ls_r, ls_s, le_r, le_s;
  logic               busy_r, busy_s, done_r, done_s;

  logic [COORD_W-1:0] step_row_s, step_col_s;
  logic [ADDR_W-1:0]  step_addr_s, step_base_s;
  logic               step_le_s, step_last_s, step_nxt_le_s;

  scan_step #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .COORD_W(COORD_W)
  ) u_step (
    .mode         (mode_r),
    .row          (row_r),
    .col          (col_r),
    .addr         (addr_r),
    .line_base    (base_r),
    .nxt_row      (step_row_s),
    .nxt_col      (step_col_s),
    .nxt_addr     (step_addr_s),
    .nxt_line_base(step_base_s),
    .line_end     (step_le_s),
    .last         (step_last_s),
    .nxt_line_end (step_nxt_le_s)
  );

  // Controller next state and datapath load/advance decisions.
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    row_s   = row_r;
    col_s   = col_r;
    addr_s  = addr_r;
    base_s  = base_r;
    valid_s = valid_r;
    ls_s    = ls_r;
    le_s    = le_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          // First element: top-left, or top-right for TTR. Diagonal
          // orders start with a single-element corner line.
          state_s = SCAN;
          mode_s  = mode;
          row_s   = '0;
          valid_s = 1'b1;
          busy_s  = 1'b1;
          ls_s    = 1'b1;
          if (mode == SCAN_TTR) begin
            col_s  = COL_MAX;
            addr_s = A_WM1;
            base_s = A_WM1;
          end else begin
            col_s  = '0;
            addr_s = '0;
            base_s = '0;
          end
          le_s = (mode == SCAN_TTL) || (mode == SCAN_TTR);
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (valid_r && addr_ready) begin
          if (step_last_s) begin
            state_s = FIN;
            valid_s = 1'b0;
            ls_s    = 1'b0;
            le_s    = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            row_s  = step_row_s;
            col_s  = step_col_s;
            addr_s = step_addr_s;
            base_s = step_base_s;
            ls_s   = step_le_s;
            le_s   = step_nxt_le_s;
          end
        end else begin
          state_s = SCAN;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        ls_s    = 1'b0;
        le_s    = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; resetIn aborts any scan without a done pulse.
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      state_r <= IDLE;
      mode_r  <= 2'b00;
      row_r   <= '0;
      col_r   <= '0;
      addr_r  <= '0;
      base_r  <= '0;
      valid_r <= 1'b0;
      ls_r    <= 1'b0;
      le_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      row_r   <= row_s;
      col_r   <= col_s;
      addr_r  <= addr_s;
      base_r  <= base_s;
      valid_r <= valid_s;
      ls_r    <= ls_s;
      le_r    <= le_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign addr_valid = valid_r;
  assign addr       = addr_r;
  assign line_start = ls_r;
  assign line_end   = le_r;
  assign busy       = busy_r;
  assign done       = done_r;
`ifdef SCAN_COORD_EN
  assign row_out    = row_r;
  assign col_out    = col_r;
`endif

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed bench for scan_addr_gen: a 4x3 instance exercises all four scan
// orders, backpressure and ignored starts; a default 150x150 instance covers
// a full row-major frame and a mid-scan reset.
module tb_scan_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetIn;
  logic        s_start, s_ready, s_valid, s_ls, s_le, s_busy, s_done;
  logic [1:0]  s_mode;
  logic [3:0]  s_addr;
  logic        b_start, b_ready, b_valid, b_ls, b_le, b_busy, b_done;
  logic [1:0]  b_mode;
  logic [14:0] b_addr;
`ifdef SCAN_COORD_EN
  logic [1:0]  s_row, s_col;
  logic [7:0]  b_row, b_col;
`endif

  int errors = 0;
  int checks = 0;

  int exp_lr[12]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
  int exp_ud[12]  = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
  int exp_ttl[12] = '{0, 4, 1, 8, 5, 2, 9, 6, 3, 10, 7, 11};
  int exp_ttr[12] = '{3, 7, 2, 11, 6, 1, 10, 5, 0, 9, 4, 8};

  scan_addr_gen #(.IMG_W(4), .IMG_H(3)) u_small (
    .clk       (clk),
    .resetIn   (resetIn),
    .start     (s_start),
    .mode      (s_mode),
    .addr_valid(s_valid),
    .addr_ready(s_ready),
    .addr      (s_addr),
    .line_start(s_ls),
    .line_end  (s_le),
    .busy      (s_busy),
`ifdef SCAN_COORD_EN
    .row_out   (s_row),
    .col_out   (s_col),
`endif
    .done      (s_done)
  );

  scan_addr_gen u_big (
    .clk       (clk),
    .resetIn   (resetIn),
    .start     (b_start),
    .mode      (b_mode),
    .addr_valid(b_valid),
    .addr_ready(b_ready),
    .addr      (b_addr),
    .line_start(b_ls),
    .line_end  (b_le),
    .busy      (b_busy),
`ifdef SCAN_COORD_EN
    .row_out   (b_row),
    .col_out   (b_col),
`endif
    .done      (b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one 4x3 frame; bp enables random backpressure plus a mid-scan start.
  task automatic run_small(input string name, input logic [1:0] m, input int exp_a[12],
                           input logic [11:0] smask, input logic [11:0] emask, input bit bp);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit pulsed = 1'b0;
    logic [3:0] h_addr = 4'd0;
    logic h_ls = 1'b0;
    logic h_le = 1'b0;
    s_mode  = m;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check({name, " first_valid"}, 32'(s_valid), 32'd1);
    check({name, " busy"}, 32'(s_busy), 32'd1);
    while (k < 12 && cyc < 400) begin
      if (stalled) begin
        check({name, " hold_addr"}, 32'(s_addr), 32'(h_addr));
        check({name, " hold_ls"}, 32'(s_ls), 32'(h_ls));
        check({name, " hold_le"}, 32'(s_le), 32'(h_le));
      end
      check({name, " no_early_done"}, 32'(s_done), 32'd0);
      if (s_valid) begin
        s_ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
        if (bp && !pulsed && k == 5) begin
          s_start = 1'b1;
          pulsed  = 1'b1;
        end else begin
          s_start = 1'b0;
        end
        if (s_ready) begin
          check($sformatf("%s addr[%0d]", name, k), 32'(s_addr), 32'(exp_a[k]));
          check($sformatf("%s ls[%0d]", name, k), 32'(s_ls), 32'(smask[k]));
          check($sformatf("%s le[%0d]", name, k), 32'(s_le), 32'(emask[k]));
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_addr  = s_addr;
          h_ls    = s_ls;
          h_le    = s_le;
        end
      end else begin
        check({name, " valid_mid_scan"}, 32'(s_valid), 32'd1);
        s_ready = 1'b0;
        s_start = 1'b0;
      end
      tick();
      cyc++;
    end
    check({name, " accepted"}, 32'(k), 32'd12);
    s_ready = 1'b0;
    s_start = 1'b1;  // coincides with the done cycle: must be ignored
    check({name, " done"}, 32'(s_done), 32'd1);
    check({name, " fin_valid"}, 32'(s_valid), 32'd0);
    tick();
    s_start = 1'b0;
    check({name, " done_one_cycle"}, 32'(s_done), 32'd0);
    check({name, " idle_busy"}, 32'(s_busy), 32'd0);
    check({name, " start_in_fin_ignored"}, 32'(s_valid), 32'd0);
    tick();
    check({name, " still_idle"}, 32'(s_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    int le_cnt;
    int cyc;
    int last_a;
    bit found;

    resetIn = 1'b1;
    s_start = 1'b0; s_ready = 1'b0; s_mode = 2'b00;
    b_start = 1'b0; b_ready = 1'b0; b_mode = 2'b00;
    tick(); tick();
    check("reset s_addr", 32'(s_addr), 32'd0);
    check("reset s_valid", 32'(s_valid), 32'd0);
    check("reset s_flags", 32'({s_ls, s_le, s_busy, s_done}), 32'd0);
    check("reset b_addr", 32'(b_addr), 32'd0);
    check("reset b_flags", 32'({b_valid, b_ls, b_le, b_busy, b_done}), 32'd0);
    resetIn = 1'b0;
    tick();
    check("idle no valid", 32'(s_valid), 32'd0);

    run_small("LR",  2'b00, exp_lr,  12'b0001_0001_0001, 12'b1000_1000_1000, 1'b0);
    run_small("UD",  2'b01, exp_ud,  12'b0010_0100_1001, 12'b1001_0010_0100, 1'b0);
    run_small("TTL", 2'b10, exp_ttl, 12'b1010_0100_1011, 12'b1101_0010_0101, 1'b0);
    run_small("TTR", 2'b11, exp_ttr, 12'b1010_0100_1011, 12'b1101_0010_0101, 1'b0);
    run_small("TTL_BP", 2'b10, exp_ttl, 12'b1010_0100_1011, 12'b1101_0010_0101, 1'b1);

    // Full default-size row-major frame.
    b_mode  = 2'b00;
    b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cnt = 0; le_cnt = 0; cyc = 0; last_a = -1;
    while (!b_done && cyc < 30000) begin
      if (b_valid) begin
        cnt++;
        last_a = int'(b_addr);
        if (b_le) le_cnt++;
      end
      tick();
      cyc++;
    end
    check("big LR done", 32'(b_done), 32'd1);
    check("big LR accepts", 32'(cnt), 32'd22500);
    check("big LR last addr", 32'(last_a), 32'd22499);
    check("big LR line_ends", 32'(le_cnt), 32'd150);
    tick();

    // Column-major scan aborted by reset while addr 300 is presented.
    b_mode  = 2'b01;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 50) begin
      if (b_valid && b_addr == 15'd300) begin
        found = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    check("big UD reached 300", 32'(found), 32'd1);
    resetIn = 1'b1;
    tick();
    check("abort addr", 32'(b_addr), 32'd0);
    check("abort flags", 32'({b_valid, b_ls, b_le, b_busy, b_done}), 32'd0);
    tick();
    check("abort no done", 32'(b_done), 32'd0);
    resetIn = 1'b0;
    tick();
    check("post abort idle", 32'({b_valid, b_done}), 32'd0);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("restart valid", 32'(b_valid), 32'd1);
    check("restart addr", 32'(b_addr), 32'd0);
    tick();
    check("restart second addr", 32'(b_addr), 32'd150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
